// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with ID-stage early redirect and a one-cycle registered EX mispredict recovery.
// Optional `BRANCH_PERF_EN adds BranchCount / MispredCount performance counters.
module branch_predict_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IdValid,
  input  logic        IdIsBranch,
  input  logic        IdIsJal,
  input  logic [31:0] IdPc,
  input  logic [31:0] IdTarget,
  output logic        IdPredTaken,
  output logic        IdRedirect,
  output logic [31:0] IdRedirectPc,
  input  logic        ExValid,
  input  logic        ExIsBranch,
  input  logic        ExIsJump,
  input  logic [31:0] ExPc,
  input  logic        ExPredTaken,
  input  logic        BranchTaken,
  input  logic [31:0] NewPc,
  output logic        RedirectValid,
  output logic [31:0] RedirectPc,
  output logic        FlushIfId,
  output logic        FlushIdEx
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
`endif
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [IDX_W-1:0]       w_id_idx;
  logic [IDX_W-1:0]       w_ex_idx;
  logic [BHT_ENTRIES-1:0] w_ctr_msb;
  logic                   w_run;
  logic                   w_mispredict;
  logic                   w_train;
  logic                   w_pred_taken;

  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic        r_flush_if_id;
  logic        r_flush_id_ex;
  logic        w_redirect_valid_next;
  logic [31:0] w_redirect_pc_next;
  logic        w_flush_next;

  logic w_unused_pc_bits;

  assign w_id_idx = IdPc[IDX_W+1:2];
  assign w_ex_idx = ExPc[IDX_W+1:2];
  assign w_unused_pc_bits = &{1'b0, IdPc[31:IDX_W+2], IdPc[1:0],
                              ExPc[31:IDX_W+2], ExPc[1:0]};

  assign w_run        = (r_state == ST_RUN);
  assign w_mispredict = w_run & ExValid & (ExIsBranch | ExIsJump) &
                        (ExPredTaken != BranchTaken);
  assign w_train      = w_run & ExValid & ExIsBranch;

  // One saturating counter per entry; only the MSB (direction) leaves the entry.
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= 2'b01;
        end else if (w_train && (w_ex_idx == IDX_W'(gi))) begin
          if (BranchTaken && (r_cnt != 2'b11)) begin
            r_cnt <= r_cnt + 2'd1;
          end else if (!BranchTaken && (r_cnt != 2'b00)) begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
      end
      assign w_ctr_msb[gi] = r_cnt[1];
    end
  endgenerate

  // Table read sees the pre-update value when EX trains the same entry this cycle.
  assign w_pred_taken = w_run & IdValid &
                        ((IdIsBranch & w_ctr_msb[w_id_idx]) | IdIsJal);

  assign IdPredTaken  = w_pred_taken;
  assign IdRedirect   = w_pred_taken & ~w_mispredict;
  assign IdRedirectPc = IdTarget;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_redirect_valid_next = 1'b0;
    w_redirect_pc_next    = 32'd0;
    w_flush_next          = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mispredict) begin
          w_state_next          = ST_RECOVER;
          w_redirect_valid_next = 1'b1;
          w_redirect_pc_next    = NewPc;
          w_flush_next          = 1'b1;
        end
      end
      ST_RECOVER: begin
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_flush_if_id    <= 1'b0;
      r_flush_id_ex    <= 1'b0;
    end else begin
      r_redirect_valid <= w_redirect_valid_next;
      r_redirect_pc    <= w_redirect_pc_next;
      r_flush_if_id    <= w_flush_next;
      r_flush_id_ex    <= w_flush_next;
    end
  end

  assign RedirectValid = r_redirect_valid;
  assign RedirectPc    = r_redirect_pc;
  assign FlushIfId     = r_flush_if_id;
  assign FlushIdEx     = r_flush_id_ex;

`ifdef BRANCH_PERF_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispred_count;

  // Both qualifiers already exclude RECOVER, so the counts freeze there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_count  <= 32'd0;
      r_mispred_count <= 32'd0;
    end else begin
      if (w_train) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mispredict) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  assign BranchCount  = r_branch_count;
  assign MispredCount = r_mispred_count;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: redirect scoreboard plus a small counter model.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        IdValid, IdIsBranch, IdIsJal;
  logic [31:0] IdPc, IdTarget;
  logic        IdPredTaken, IdRedirect;
  logic [31:0] IdRedirectPc;
  logic        ExValid, ExIsBranch, ExIsJump;
  logic [31:0] ExPc;
  logic        ExPredTaken, BranchTaken;
  logic [31:0] NewPc;
  logic        RedirectValid;
  logic [31:0] RedirectPc;
  logic        FlushIfId, FlushIdEx;
`ifdef BRANCH_PERF_EN
  logic [31:0] BranchCount, MispredCount;
`endif

  always #5 clk = ~clk;

  branch_predict_ctrl #(.BHT_ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .IdValid(IdValid), .IdIsBranch(IdIsBranch), .IdIsJal(IdIsJal),
    .IdPc(IdPc), .IdTarget(IdTarget),
    .IdPredTaken(IdPredTaken), .IdRedirect(IdRedirect), .IdRedirectPc(IdRedirectPc),
    .ExValid(ExValid), .ExIsBranch(ExIsBranch), .ExIsJump(ExIsJump),
    .ExPc(ExPc), .ExPredTaken(ExPredTaken), .BranchTaken(BranchTaken), .NewPc(NewPc),
    .RedirectValid(RedirectValid), .RedirectPc(RedirectPc),
    .FlushIfId(FlushIfId), .FlushIdEx(FlushIdEx)
`ifdef BRANCH_PERF_EN
    , .BranchCount(BranchCount), .MispredCount(MispredCount)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  mdl_ctr[16];
  logic [31:0] exp_branches;
  logic [31:0] exp_mispreds;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    IdValid = 0; IdIsBranch = 0; IdIsJal = 0; IdPc = 0; IdTarget = 0;
  endtask

  task automatic clear_ex();
    ExValid = 0; ExIsBranch = 0; ExIsJump = 0; ExPc = 0;
    ExPredTaken = 0; BranchTaken = 0; NewPc = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_id();
    clear_ex();
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 16; i++) mdl_ctr[i] = 2'b01;
    exp_q.delete();
    exp_branches = 0;
    exp_mispreds = 0;
  endtask

  task automatic id_query(input logic [31:0] pc, input logic br, input logic jal,
                          input logic [31:0] tgt);
    IdValid = 1; IdIsBranch = br; IdIsJal = jal; IdPc = pc; IdTarget = tgt;
    #2;
  endtask

  // Drives one EX resolution in a RUN cycle; returns one cycle later (in RECOVER if it mispredicted).
  task automatic run_ex(input logic [31:0] pc, input logic jump, input logic pred,
                        input logic taken, input logic [31:0] npc);
    int k;
    ExValid = 1; ExIsBranch = !jump; ExIsJump = jump; ExPc = pc;
    ExPredTaken = pred; BranchTaken = taken; NewPc = npc;
    if (pred != taken) begin
      exp_q.push_back(npc);
      exp_mispreds++;
    end
    if (!jump) begin
      k = int'(pc[5:2]);
      exp_branches++;
      if (taken && mdl_ctr[k] != 2'b11) mdl_ctr[k] = mdl_ctr[k] + 2'd1;
      else if (!taken && mdl_ctr[k] != 2'b00) mdl_ctr[k] = mdl_ctr[k] - 2'd1;
    end
    tick();
    clear_ex();
  endtask

  task automatic test_reset();
    n_checks++;
    if (RedirectValid !== 1'b0 || FlushIfId !== 1'b0 || FlushIdEx !== 1'b0)
      $display("FAIL reset_regs: got rv=%0b fif=%0b fie=%0b want 0/0/0", RedirectValid, FlushIfId, FlushIdEx);
    else n_pass++;
    n_checks++;
    if (RedirectPc !== 32'h0) $display("FAIL reset_rpc: got %h want 0", RedirectPc);
    else n_pass++;
    id_query(32'h40, 1, 0, 32'h100);
    n_checks++;
    if (IdPredTaken !== 1'b0 || IdRedirect !== 1'b0)
      $display("FAIL reset_pred: got pt=%0b rd=%0b want 0/0", IdPredTaken, IdRedirect);
    else n_pass++;
    n_checks++;
    if (IdRedirectPc !== 32'h100) $display("FAIL reset_idrpc: got %h want 00000100", IdRedirectPc);
    else n_pass++;
    $display("test_reset done");
    clear_id();
  endtask

  task automatic test_train();
    logic [31:0] e;
    for (int n = 0; n < 2; n++) begin
      run_ex(32'h40, 0, 0, 1, 32'h80);
      e = exp_q.pop_front();
      n_checks++;
      if (RedirectValid !== 1'b1 || RedirectPc !== e)
        $display("FAIL train_redirect%0d: got rv=%0b pc=%h want 1 %h", n, RedirectValid, RedirectPc, e);
      else n_pass++;
      n_checks++;
      if (FlushIfId !== 1'b1 || FlushIdEx !== 1'b1)
        $display("FAIL train_flush%0d: got %0b%0b want 11", n, FlushIfId, FlushIdEx);
      else n_pass++;
      tick();
      n_checks++;
      if (RedirectValid !== 1'b0 || FlushIfId !== 1'b0 || FlushIdEx !== 1'b0)
        $display("FAIL train_clear%0d: got rv=%0b fl=%0b%0b want 0 00", n, RedirectValid, FlushIfId, FlushIdEx);
      else n_pass++;
      $display("train taken #%0d at 0x40 redirect %h", n, e);
    end
    id_query(32'h40, 1, 0, 32'h80);
    n_checks++;
    if (IdPredTaken !== 1'b1 || IdRedirect !== 1'b1 || IdRedirectPc !== 32'h80)
      $display("FAIL train_pred: got pt=%0b rd=%0b pc=%h want 1 1 00000080", IdPredTaken, IdRedirect, IdRedirectPc);
    else n_pass++;
    clear_id();
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    for (int n = 0; n < 5; n++) begin
      run_ex(32'h40, 0, 1, 1, 32'h80);
      n_checks++;
      if (RedirectValid !== 1'b0) $display("FAIL sat_taken%0d: got rv=%0b want 0", n, RedirectValid);
      else n_pass++;
      $display("sat taken #%0d correct prediction", n);
    end
    for (int n = 0; n < 2; n++) begin
      run_ex(32'h40, 0, 1, 0, 32'h44);
      e = exp_q.pop_front();
      n_checks++;
      if (RedirectValid !== 1'b1 || RedirectPc !== e)
        $display("FAIL sat_nt%0d_redirect: got rv=%0b pc=%h want 1 %h", n, RedirectValid, RedirectPc, e);
      else n_pass++;
      tick();
      id_query(32'h40, 1, 0, 32'h80);
      n_checks++;
      if (IdPredTaken !== ((n == 0) ? 1'b1 : 1'b0))
        $display("FAIL sat_nt%0d_pred: got %0b want %0b", n, IdPredTaken, (n == 0) ? 1'b1 : 1'b0);
      else n_pass++;
      $display("sat not-taken #%0d pred now %0b", n, IdPredTaken);
      clear_id();
    end
  endtask

  task automatic test_jalr();
    logic [31:0] e;
    run_ex(32'h40, 1, 0, 1, 32'h1234);
    e = exp_q.pop_front();
    n_checks++;
    if (RedirectValid !== 1'b1 || RedirectPc !== e)
      $display("FAIL jalr_redirect: got rv=%0b pc=%h want 1 %h", RedirectValid, RedirectPc, e);
    else n_pass++;
    tick();
    id_query(32'h40, 1, 0, 32'h80);
    n_checks++;
    if (IdPredTaken !== 1'b0) $display("FAIL jalr_notrain: got pt=%0b want 0", IdPredTaken);
    else n_pass++;
    id_query(32'h200, 0, 1, 32'h300);
    n_checks++;
    if (IdPredTaken !== 1'b1 || IdRedirect !== 1'b1 || IdRedirectPc !== 32'h300)
      $display("FAIL jal_pred: got pt=%0b rd=%0b pc=%h want 1 1 00000300", IdPredTaken, IdRedirect, IdRedirectPc);
    else n_pass++;
    $display("jalr redirect %h, jal predicted taken", e);
    clear_id();
  endtask

  task automatic test_same_cycle();
    logic [31:0] e;
    run_ex(32'h40, 0, 0, 1, 32'h80);
    void'(exp_q.pop_front());
    tick();
    // EX at 0x84 (index 1) mispredicts while ID at 0x40 (index 0, now weakly taken) predicts taken.
    ExValid = 1; ExIsBranch = 1; ExPc = 32'h84; ExPredTaken = 0; BranchTaken = 1; NewPc = 32'h200;
    exp_q.push_back(32'h200);
    exp_branches++;
    exp_mispreds++;
    mdl_ctr[1] = mdl_ctr[1] + 2'd1;
    id_query(32'h40, 1, 0, 32'h500);
    n_checks++;
    if (IdPredTaken !== 1'b1 || IdRedirect !== 1'b0)
      $display("FAIL same_suppress: got pt=%0b rd=%0b want 1 0", IdPredTaken, IdRedirect);
    else n_pass++;
    tick();
    ExPc = 32'h40; NewPc = 32'h999;
    #1;
    n_checks++;
    if (IdPredTaken !== 1'b0 || IdRedirect !== 1'b0)
      $display("FAIL recover_id: got pt=%0b rd=%0b want 0 0", IdPredTaken, IdRedirect);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (RedirectValid !== 1'b1 || RedirectPc !== e)
      $display("FAIL same_redirect: got rv=%0b pc=%h want 1 %h", RedirectValid, RedirectPc, e);
    else n_pass++;
    tick();
    clear_ex();
    clear_id();
    n_checks++;
    if (RedirectValid !== 1'b0) $display("FAIL recover_nodetect: got rv=%0b want 0", RedirectValid);
    else n_pass++;
    run_ex(32'h40, 0, 1, 0, 32'h44);
    e = exp_q.pop_front();
    tick();
    id_query(32'h40, 1, 0, 32'h80);
    n_checks++;
    if (IdPredTaken !== 1'b0) $display("FAIL recover_notrain: got pt=%0b want 0", IdPredTaken);
    else n_pass++;
    $display("same-cycle: EX redirect %h, ID suppressed, RECOVER inert", 32'h200);
    clear_id();
  endtask

`ifdef BRANCH_PERF_EN
  task automatic test_perf();
    n_checks++;
    if (BranchCount !== exp_branches)
      $display("FAIL perf_branch: got %0d want %0d", BranchCount, exp_branches);
    else n_pass++;
    n_checks++;
    if (MispredCount !== exp_mispreds)
      $display("FAIL perf_mispred: got %0d want %0d", MispredCount, exp_mispreds);
    else n_pass++;
    $display("perf counts branch=%0d mispred=%0d", BranchCount, MispredCount);
  endtask
`endif

  task automatic test_reset_recover();
    logic [31:0] e;
    run_ex(32'h40, 0, 0, 1, 32'h80);
    e = exp_q.pop_front();
    n_checks++;
    if (RedirectValid !== 1'b1 || RedirectPc !== e)
      $display("FAIL rr_redirect: got rv=%0b pc=%h want 1 %h", RedirectValid, RedirectPc, e);
    else n_pass++;
    rst = 1;
    tick();
    n_checks++;
    if (RedirectValid !== 1'b0 || RedirectPc !== 32'h0 || FlushIfId !== 1'b0 || FlushIdEx !== 1'b0)
      $display("FAIL rr_outputs: got rv=%0b pc=%h fl=%0b%0b want 0 0 00", RedirectValid, RedirectPc, FlushIfId, FlushIdEx);
    else n_pass++;
    rst = 0;
    for (int i = 0; i < 16; i++) mdl_ctr[i] = 2'b01;
    exp_branches = 0;
    exp_mispreds = 0;
`ifdef BRANCH_PERF_EN
    test_perf();
`endif
    id_query(32'h40, 1, 0, 32'h80);
    n_checks++;
    if (IdPredTaken !== 1'b0) $display("FAIL rr_ctr: got pt=%0b want 0", IdPredTaken);
    else n_pass++;
    clear_id();
    run_ex(32'h48, 0, 0, 1, 32'h88);
    e = exp_q.pop_front();
    n_checks++;
    if (RedirectValid !== 1'b1 || RedirectPc !== e)
      $display("FAIL rr_run: got rv=%0b pc=%h want 1 %h", RedirectValid, RedirectPc, e);
    else n_pass++;
    tick();
    $display("reset during RECOVER restored defaults");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    test_reset();
    test_train();
    test_saturation();
    test_jalr();
    test_same_cycle();
`ifdef BRANCH_PERF_EN
    test_perf();
`endif
    test_reset_recover();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
